spi_lcd_rx: RTL and testbench
=============================

Name: spi_lcd_rx

Overview:
- SPI display-side receiver: the panel end of the 4-wire link (sck/mosi/cs/dc) that our display-update logic drives.
- Oversamples the SPI pins on the system clock, assembles bytes and decodes the column-set, row-set and memory-write commands.
- Emits addressed RGB565 pixel writes plus a command strobe.
- Serves as a bench monitor/scoreboard front end and as a framebuffer-writer front end for simulated panels.

Parameters:
- X_W, 8, column address width (pix_x, window X registers).
- Y_W, 8, row address width (pix_y, window Y registers).
- SYNC_STAGES, 2, synchronizer flops on each SPI input (min 2).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous active-high reset
- spi_sck  in  1  SPI clock, mode 0, idle low, sampled on rising edge
- spi_mosi  in  1  serial data, MSB first
- spi_cs  in  1  chip select, active low
- spi_dc  in  1  0 = command byte, 1 = data/parameter byte
- cmd_valid  out  1  one-cycle strobe, command byte received
- cmd_code  out  8  last command byte; held until next command
- pix_valid  out  1  one-cycle strobe, pixel complete
- pix_x  out  X_W  column of the pixel
- pix_y  out  Y_W  row of the pixel
- pix_data  out  16  RGB565 value {first byte, second byte}
- protocol_err  out  1  one-cycle strobe on protocol violation

Behaviour:
- Reset: all outputs 0. Window XS=0, XE=2^X_W-1, YS=0, YE=2^Y_W-1. Decoder state IDLE. Bit counter 0.
- Sampling:
  - All four SPI inputs pass through SYNC_STAGES flops, plus one edge-detect flop on sck.
  - A synced sck 0->1 while synced cs=0 shifts in mosi. Requires sck high and low phases each >= 2 clk.
- Byte assembly:
  - The 8th bit completes a byte, registered together with dc as sampled at that bit. The bit counter returns to 0.
  - Synced cs=1 clears the bit counter and discards the partial byte. Decoder state is retained across cs toggles.
- Output latency: registered outputs assert exactly 1 clk after the byte-complete cycle.
- Decoder states: IDLE, CASET_P (param index 0..3), RASET_P (0..3), RAMWR_HI, RAMWR_LO.
- Any dc=0 byte:
  - cmd_valid=1; cmd_code updated.
  - Pending parameter collection and any partial pixel are aborted; the window is unchanged.
  - Next state: 0x2A -> CASET_P idx 0; 0x2B -> RASET_P idx 0; 0x2C -> RAMWR_HI with x<=XS, y<=YS; any other code -> IDLE.
- CASET/RASET parameters:
  - Four bytes: start hi, start lo, end hi, end lo. Each 16-bit value is truncated to X_W/Y_W LSBs.
  - Registers commit atomically on the 4th byte, then state goes to IDLE.
  - If start > end after truncation: no commit, protocol_err=1.
- RAMWR_HI: stores the byte, goes to RAMWR_LO.
- RAMWR_LO:
  - pix_valid=1 with pix_data={hi,lo} and the current x,y; goes back to RAMWR_HI.
  - Address advance: if x<XE, x+1. Else x<=XS and, if y<YE, y+1; else y<=YS (frame wrap).
- Data byte (dc=1) in IDLE: ignored, protocol_err=1.
- cs high between the hi and lo bytes: hi byte discarded, state returns to RAMWR_HI, x/y unchanged.
- Reset mid-byte or mid-frame: all state returns to reset values on the next clk; no strobes.

Optional Feature:
- FRAME_DONE_EN defined:
  - Extra output frame_done (1 bit), a one-cycle strobe coincident with the pix_valid of the pixel at (XE,YE).
  - Extra output pix_count (32 bits): counts pix_valid; cleared by rst and by command 0x2C.
- Not defined: neither port exists; no counter logic.

Decomposition:
- Shared package spi_lcd_pkg holds:
  - command constants CMD_CASET=8'h2A, CMD_RASET=8'h2B, CMD_RAMWR=8'h2C
  - the decoder state enum
  - RGB565 field widths
- One natural sub-module: spi_byte_rx (synchronizers, edge detect, shift register, byte_valid/byte_dc output). spi_lcd_rx instantiates it and holds the decoder FSM and address counters.

Test Plan:
- Reset, then command 0x11 with dc=0 -> cmd_valid pulse once, cmd_code=8'h11, no pix_valid.
- CASET 00 02 00 03, RASET 00 05 00 06, RAMWR, 5 pixels F800 07E0 001F FFFF 0000 -> pixels at (2,5)=F800, (3,5)=07E0, (2,6)=001F, (3,6)=FFFF, then wrap (2,5)=0000.
- CASET 00 09 00 04 -> protocol_err pulse; the next RAMWR starts at the previous XS.
- CASET 00 01 then command 0x2C -> partial params discarded, window unchanged, pixels start at the old XS,YS.
- Pulse cs high after 4 bits of a pixel hi byte, then resend full pixel AB CD -> single pix_valid, pix_data=16'hABCD at unchanged x,y.
- Data byte 0x55 after reset (IDLE) -> protocol_err pulse. With FRAME_DONE_EN: a full 2x2 window write -> frame_done on the 4th pixel and pix_count=4.

Source files
------------

// File: rtl/spi_lcd_pkg.sv
// Shared command codes, decoder state type and pixel field widths for the
// SPI display-side receiver (spi_byte_rx, spi_lcd_rx).
`timescale 1ns/1ps
package spi_lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int PIX_W = R_W + G_W + B_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET_P,
        ST_RASET_P,
        ST_RAMWR_HI,
        ST_RAMWR_LO
    } dec_state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI mode-0 byte receiver: synchronizes sck/mosi/cs/dc,
// detects synced sck rising edges and assembles MSB-first bytes.
`timescale 1ns/1ps
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       mosi,
    input  logic       cs,
    input  logic       dc,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       cs_idle
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic                   sck_prev;
    logic [6:0]             shift;
    logic [2:0]             bit_cnt;

    logic sck_s, mosi_s, cs_s, dc_s, sck_rise;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign dc_s     = dc_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign cs_idle  = cs_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync   <= '0;
            mosi_sync  <= '0;
            cs_sync    <= '1;    // deselected until the pin says otherwise
            dc_sync    <= '0;
            sck_prev   <= 1'b0;
            shift      <= '0;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs};
            dc_sync    <= {dc_sync[SYNC_STAGES-2:0], dc};
            sck_prev   <= sck_s;
            byte_valid <= 1'b0;

            if (cs_s) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                shift   <= {shift[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shift, mosi_s};
                    byte_dc    <= dc_s;
                end
            end
        end
    end

endmodule

// File: rtl/spi_lcd_rx.sv
// SPI display-side receiver: decodes CASET/RASET/RAMWR into addressed RGB565
// pixel writes. Define FRAME_DONE_EN to add frame_done and pix_count outputs.
`timescale 1ns/1ps
module spi_lcd_rx
    import spi_lcd_pkg::*;
#(
    parameter int X_W         = 8,
    parameter int Y_W         = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sck,
    input  logic             spi_mosi,
    input  logic             spi_cs,
    input  logic             spi_dc,
    output logic             cmd_valid,
    output logic [7:0]       cmd_code,
    output logic             pix_valid,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic [PIX_W-1:0] pix_data,
    output logic             protocol_err
`ifdef FRAME_DONE_EN
    ,
    output logic             frame_done,
    output logic [31:0]      pix_count
`endif
);

    logic       byte_valid, byte_dc, cs_idle;
    logic [7:0] byte_data;

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
        .clk        (clk),
        .rst        (rst),
        .sck        (spi_sck),
        .mosi       (spi_mosi),
        .cs         (spi_cs),
        .dc         (spi_dc),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_dc    (byte_dc),
        .cs_idle    (cs_idle)
    );

    dec_state_t     state, state_nxt;
    logic [1:0]     idx, idx_nxt;
    logic [7:0]     p0, p1, p2, hi;
    logic [X_W-1:0] xs, xe, x;
    logic [Y_W-1:0] ys, ye, y;
    logic [X_W-1:0] cx_lo, cx_hi;
    logic [Y_W-1:0] cy_lo, cy_hi;

    logic cmd_fire, err_fire, pix_fire, par_fire, hi_fire, addr_load;
    logic caset_commit, raset_commit;

    // Truncation to the address width happens here, before the start > end test.
    assign cx_lo = X_W'({p0, p1});
    assign cx_hi = X_W'({p2, byte_data});
    assign cy_lo = Y_W'({p0, p1});
    assign cy_hi = Y_W'({p2, byte_data});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt    = state;
        idx_nxt      = idx;
        cmd_fire     = 1'b0;
        err_fire     = 1'b0;
        pix_fire     = 1'b0;
        par_fire     = 1'b0;
        hi_fire      = 1'b0;
        addr_load    = 1'b0;
        caset_commit = 1'b0;
        raset_commit = 1'b0;

        if (byte_valid && !byte_dc) begin
            cmd_fire = 1'b1;
            idx_nxt  = '0;
            case (byte_data)
                CMD_CASET: state_nxt = ST_CASET_P;
                CMD_RASET: state_nxt = ST_RASET_P;
                CMD_RAMWR: begin
                    state_nxt = ST_RAMWR_HI;
                    addr_load = 1'b1;
                end
                default:   state_nxt = ST_IDLE;
            endcase
        end else if (byte_valid) begin
            case (state)
                ST_IDLE: err_fire = 1'b1;
                ST_CASET_P, ST_RASET_P: begin
                    if (idx == 2'd3) begin
                        state_nxt = ST_IDLE;
                        idx_nxt   = '0;
                        if (state == ST_CASET_P) begin
                            err_fire     = (cx_lo > cx_hi);
                            caset_commit = !(cx_lo > cx_hi);
                        end else begin
                            err_fire     = (cy_lo > cy_hi);
                            raset_commit = !(cy_lo > cy_hi);
                        end
                    end else begin
                        par_fire = 1'b1;
                        idx_nxt  = idx + 2'd1;
                    end
                end
                ST_RAMWR_HI: begin
                    hi_fire   = 1'b1;
                    state_nxt = ST_RAMWR_LO;
                end
                ST_RAMWR_LO: begin
                    pix_fire  = 1'b1;
                    state_nxt = ST_RAMWR_HI;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (cs_idle && state == ST_RAMWR_LO) begin
            // Deselect between the two pixel bytes drops the stored high byte.
            state_nxt = ST_RAMWR_HI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid    <= 1'b0;
            cmd_code     <= '0;
            pix_valid    <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_data     <= '0;
            protocol_err <= 1'b0;
            p0           <= '0;
            p1           <= '0;
            p2           <= '0;
            hi           <= '0;
            xs           <= '0;
            xe           <= '1;
            ys           <= '0;
            ye           <= '1;
            x            <= '0;
            y            <= '0;
        end else begin
            cmd_valid    <= cmd_fire;
            pix_valid    <= pix_fire;
            protocol_err <= err_fire;

            if (cmd_fire) cmd_code <= byte_data;
            if (hi_fire)  hi <= byte_data;

            if (par_fire) begin
                case (idx)
                    2'd0:    p0 <= byte_data;
                    2'd1:    p1 <= byte_data;
                    default: p2 <= byte_data;
                endcase
            end

            if (caset_commit) begin
                xs <= cx_lo;
                xe <= cx_hi;
            end
            if (raset_commit) begin
                ys <= cy_lo;
                ye <= cy_hi;
            end

            if (addr_load) begin
                x <= xs;
                y <= ys;
            end else if (pix_fire) begin
                pix_x    <= x;
                pix_y    <= y;
                pix_data <= {hi, byte_data};
                if (x < xe) begin
                    x <= x + X_W'(1);
                end else begin
                    x <= xs;
                    y <= (y < ye) ? y + Y_W'(1) : ys;
                end
            end
        end
    end

`ifdef FRAME_DONE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
            pix_count  <= '0;
        end else begin
            frame_done <= pix_fire && (x == xe) && (y == ye);
            if (cmd_fire && byte_data == CMD_RAMWR) pix_count <= '0;
            else if (pix_fire)                      pix_count <= pix_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Scoreboard bench for spi_lcd_rx: a byte-level reference model pushes expected
// strobes into a queue, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_spi_lcd_rx;

    localparam int X_W         = 8;
    localparam int Y_W         = 8;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 80;   // sck half period, 4 clk

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sck = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1, spi_dc = 1'b0;
    logic        cmd_valid, pix_valid, protocol_err;
    logic [7:0]  cmd_code;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic [15:0] pix_data;
`ifdef FRAME_DONE_EN
    logic        frame_done;
    logic [31:0] pix_count;
`endif

    always #10 clk = ~clk;

    spi_lcd_rx #(.X_W(X_W), .Y_W(Y_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_cs       (spi_cs),
        .spi_dc       (spi_dc),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_data     (pix_data),
        .protocol_err (protocol_err)
`ifdef FRAME_DONE_EN
        ,
        .frame_done   (frame_done),
        .pix_count    (pix_count)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {K_CMD, K_PIX, K_ERR} kind_t;
    typedef struct {
        kind_t       kind;
        logic [7:0]  code;
        int          x;
        int          y;
        logic [15:0] data;
        bit          fd;
        int          cnt;
    } ev_t;

    localparam int M_IDLE = 0, M_CASET = 1, M_RASET = 2, M_HI = 3, M_LO = 4;

    ev_t        exp_q[$];
    logic [7:0] m_params[$];
    int         m_mode, m_xs, m_xe, m_ys, m_ye, m_x, m_y, m_cnt;
    logic [7:0] m_hi, m_last_cmd;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_xs = 0; m_xe = (1 << X_W) - 1;
        m_ys = 0; m_ye = (1 << Y_W) - 1;
        m_x = 0; m_y = 0; m_cnt = 0;
        m_hi = 8'h00; m_last_cmd = 8'h00;
        m_params.delete();
    endtask

    task automatic model_byte(input bit dc, input logic [7:0] b);
        ev_t e;
        int  lim, s, en;
        e.kind = K_CMD; e.code = m_last_cmd; e.x = 0; e.y = 0;
        e.data = 16'h0; e.fd = 1'b0; e.cnt = 0;
        if (!dc) begin
            m_last_cmd = b;
            e.code = b;
            m_params.delete();
            case (b)
                8'h2A: m_mode = M_CASET;
                8'h2B: m_mode = M_RASET;
                8'h2C: begin m_mode = M_HI; m_x = m_xs; m_y = m_ys; m_cnt = 0; end
                default: m_mode = M_IDLE;
            endcase
            exp_q.push_back(e);
        end else if (m_mode == M_IDLE) begin
            e.kind = K_ERR;
            exp_q.push_back(e);
        end else if (m_mode == M_CASET || m_mode == M_RASET) begin
            m_params.push_back(b);
            if (m_params.size() == 4) begin
                lim = (m_mode == M_CASET) ? (1 << X_W) : (1 << Y_W);
                s   = int'({m_params[0], m_params[1]}) % lim;
                en  = int'({m_params[2], m_params[3]}) % lim;
                if (s > en) begin
                    e.kind = K_ERR;
                    exp_q.push_back(e);
                end else if (m_mode == M_CASET) begin
                    m_xs = s; m_xe = en;
                end else begin
                    m_ys = s; m_ye = en;
                end
                m_mode = M_IDLE;
                m_params.delete();
            end
        end else if (m_mode == M_HI) begin
            m_hi = b;
            m_mode = M_LO;
        end else begin
            m_cnt++;
            e.kind = K_PIX; e.x = m_x; e.y = m_y; e.data = {m_hi, b};
            e.fd = (m_x == m_xe) && (m_y == m_ye); e.cnt = m_cnt;
            exp_q.push_back(e);
            if (m_x < m_xe) m_x++;
            else begin
                m_x = m_xs;
                m_y = (m_y < m_ye) ? m_y + 1 : m_ys;
            end
            m_mode = M_HI;
        end
    endtask

    // ---------------- monitor ----------------
    ev_t   mon_e;
    kind_t got_kind;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1 || pix_valid === 1'b1 || protocol_err === 1'b1) begin
            check("single_strobe", 32'(cmd_valid) + 32'(pix_valid) + 32'(protocol_err), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe_queue_size", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                if (cmd_valid)      got_kind = K_CMD;
                else if (pix_valid) got_kind = K_PIX;
                else                got_kind = K_ERR;
                check("strobe_kind", 32'(got_kind), 32'(mon_e.kind));
                check("cmd_code", 32'(cmd_code), 32'(mon_e.code));
                if (mon_e.kind == K_PIX) begin
                    check("pix_x", 32'(pix_x), 32'(mon_e.x));
                    check("pix_y", 32'(pix_y), 32'(mon_e.y));
                    check("pix_data", 32'(pix_data), 32'(mon_e.data));
`ifdef FRAME_DONE_EN
                    check("pix_count", pix_count, 32'(mon_e.cnt));
`endif
                end
`ifdef FRAME_DONE_EN
                check("frame_done", 32'(frame_done), 32'(mon_e.fd));
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_bits(input bit dc, input logic [7:0] b, input int n);
        spi_dc = dc;
        for (int i = 0; i < n; i++) begin
            spi_mosi = b[7-i];
            #(HALF) spi_sck = 1'b1;
            #(HALF) spi_sck = 1'b0;
        end
    endtask

    task automatic send_byte(input bit dc, input logic [7:0] b);
        model_byte(dc, b);   // expectation is queued before the DUT can respond
        send_bits(dc, b, 8);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_byte(1'b0, b);
    endtask

    task automatic send_pix(input logic [15:0] d);
        send_byte(1'b1, d[15:8]);
        send_byte(1'b1, d[7:0]);
    endtask

    task automatic set_win(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
        send_cmd(cmd);
        send_byte(1'b1, s[15:8]);
        send_byte(1'b1, s[7:0]);
        send_byte(1'b1, e[15:8]);
        send_byte(1'b1, e[7:0]);
    endtask

    task automatic cs_pulse();
        #(HALF) spi_cs = 1'b1;
        if (m_mode == M_LO) m_mode = M_HI;
        #(2*HALF) spi_cs = 1'b0;
        #(HALF);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout_queue_size", 32'(exp_q.size()), 32'd0);
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_code", 32'(cmd_code), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_x", 32'(pix_x), 32'd0);
        check("rst_pix_y", 32'(pix_y), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_protocol_err", 32'(protocol_err), 32'd0);
`ifdef FRAME_DONE_EN
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_pix_count", pix_count, 32'd0);
`endif
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    int          act, n, gl;
    logic [15:0] s16, e16;
    logic [7:0]  b;

    initial begin
        model_reset();
        do_reset();
        #(HALF) spi_cs = 1'b0;
        #(HALF);

        // plain non-window command
        send_cmd(8'h11);
        wait_drain();

        // 2x2 window, 5 pixels, frame wrap
        set_win(8'h2A, 16'h0002, 16'h0003);
        set_win(8'h2B, 16'h0005, 16'h0006);
        send_cmd(8'h2C);
        send_pix(16'hF800);
        send_pix(16'h07E0);
        send_pix(16'h001F);
        send_pix(16'hFFFF);
        send_pix(16'h0000);
        wait_drain();

        // inverted window rejected
        set_win(8'h2A, 16'h0009, 16'h0004);
        send_cmd(8'h2C);
        send_pix(16'h1357);
        wait_drain();

        // partial CASET aborted by RAMWR
        send_cmd(8'h2A);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h01);
        send_cmd(8'h2C);
        send_pix(16'h2468);
        wait_drain();

        // cs glitch mid hi byte, then cs glitch between hi and lo
        send_cmd(8'h2C);
        send_bits(1'b1, 8'hAB, 4);
        cs_pulse();
        send_pix(16'hABCD);
        send_byte(1'b1, 8'h77);
        cs_pulse();
        send_pix(16'h1234);
        wait_drain();

        // data byte in IDLE after reset
        do_reset();
        send_byte(1'b1, 8'h55);
        wait_drain();

        // reset in the middle of a frame and of a byte
        send_cmd(8'h2C);
        send_pix(16'hCAFE);
        send_bits(1'b1, 8'hF0, 4);
        wait_drain();
        do_reset();
        repeat (8) @(posedge clk);
        #1;
        send_cmd(8'h2C);
        send_pix(16'hBEEF);
        wait_drain();

        // randomized traffic
        for (int it = 0; it < 30; it++) begin
            act = $urandom_range(0, 5);
            case (act)
                0: begin
                    s16 = 16'($urandom_range(0, 250)) | (16'($urandom_range(0, 255)) << 8);
                    e16 = 16'(s16[7:0] + 8'($urandom_range(0, 3))) | (16'($urandom_range(0, 255)) << 8);
                    if ($urandom_range(0, 4) == 0) e16[7:0] = s16[7:0] - 8'd1;
                    set_win(8'h2A, s16, e16);
                    s16 = 16'($urandom_range(0, 250));
                    e16 = s16 + 16'($urandom_range(0, 3));
                    set_win(8'h2B, s16, e16);
                end
                1: begin
                    send_cmd(8'h2C);
                    n = $urandom_range(1, 6);
                    for (int p = 0; p < n; p++) begin
                        gl = $urandom_range(0, 5);
                        if (gl == 0) begin
                            send_byte(1'b1, 8'($urandom));
                            cs_pulse();
                        end else if (gl == 1) begin
                            send_bits(1'b1, 8'($urandom), $urandom_range(1, 7));
                            cs_pulse();
                        end
                        send_pix(16'($urandom));
                    end
                end
                2: begin
                    b = 8'($urandom);
                    if (b >= 8'h2A && b <= 8'h2C) b = 8'h29;
                    send_cmd(b);
                end
                3: send_byte(1'b1, 8'($urandom));
                4: begin
                    send_cmd(8'h2A);
                    n = $urandom_range(0, 3);
                    for (int p = 0; p < n; p++) send_byte(1'b1, 8'($urandom));
                    send_cmd(8'h2C);
                    send_pix(16'($urandom));
                end
                default: begin
                    send_bits($urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(1, 7));
                    cs_pulse();
                end
            endcase
            wait_drain();
        end

        check("leftover_expectations", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
